// File: rtl/fir_stream_ctrl_pkg.sv
// Shared definitions for the FIR stream controller: sequencer states and default sizing.
package fir_stream_ctrl_pkg;

    localparam int TAPS      = 8;
    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_TMO   = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// Stream bundle between the controller, its sample source, the FIR core and the result sink.
interface fir_stream_ctrl_if
    import fir_stream_ctrl_pkg::*;
#(
    parameter int N = DEF_N
) ();

    logic              src_vld;
    logic [N-1:0]      src_data;
    logic              src_rdy;

    logic [TAPS*N-1:0] fir_coeffs;
    logic [N-1:0]      fir_din_data;
    logic              fir_din_vld;
    logic              fir_dout_busy;
    logic              fir_dout_vld;
    logic [N+2:0]      fir_dout_data;

    logic              snk_vld;
    logic [N+2:0]      snk_data;
    logic              snk_rdy;

    modport master (
        input  src_vld, src_data, fir_dout_vld, fir_dout_data, snk_rdy,
        output src_rdy, fir_coeffs, fir_din_data, fir_din_vld, fir_dout_busy,
               snk_vld, snk_data
    );

    modport slave (
        output src_vld, src_data, fir_dout_vld, fir_dout_data, snk_rdy,
        input  src_rdy, fir_coeffs, fir_din_data, fir_din_vld, fir_dout_busy,
               snk_vld, snk_data
    );

endinterface

// File: rtl/fir_out_skid.sv
// One-entry result buffer between the FIR output and the sink; full doubles as FIR backpressure.
module fir_out_skid #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // A push is only honoured while empty, so push and pop can never coincide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (full_q && pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/fir_stream_ctrl.sv
// Frame sequencer in front of an 8-tap FIR: coefficient file, one-sample-in-flight issue/wait loop,
// result buffering and a wait watchdog.
module fir_stream_ctrl
    import fir_stream_ctrl_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO   = DEF_TMO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we_i,
    input  logic [2:0]       cfg_addr_i,
    input  logic [N-1:0]     cfg_data_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] frame_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_tmo_o,
    fir_stream_ctrl_if.master bus
);

    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [CNT_W-1:0] frameLen_q;
    logic [CNT_W-1:0] frameLen_d;
    logic [CNT_W-1:0] smpCnt_q;
    logic [CNT_W-1:0] smpCnt_d;
    logic [TW-1:0]    tmoCnt_q;
    logic [TW-1:0]    tmoCnt_d;
    logic [N-1:0]     dinData_q;
    logic [N-1:0]     dinData_d;
    logic             dinVld_q;
    logic             dinVld_d;
    logic             done_q;
    logic             done_d;
    logic             errTmo_q;
    logic             errTmo_d;
    logic [N-1:0]     coeff_q [TAPS];
    logic [N-1:0]     coeff_d [TAPS];

    logic             srcRdy;
    logic             capture;
    logic             bufFull;
    logic [N+2:0]     bufData;
    logic [TAPS*N-1:0] coeffsFlat;

    // Results are only taken while a sample is outstanding and the buffer has room.
    assign capture = (state_q == ST_WAIT) && bus.fir_dout_vld && !bufFull;

    fir_out_skid #(
        .W (N + 3)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (capture),
        .data_i (bus.fir_dout_data),
        .pop_i  (bus.snk_rdy),
        .full_o (bufFull),
        .data_o (bufData)
    );

    always_comb begin
        coeff_d = coeff_q;
        if (cfg_we_i && (state_q == ST_IDLE)) begin
            coeff_d[cfg_addr_i] = cfg_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        frameLen_d = frameLen_q;
        smpCnt_d   = smpCnt_q;
        tmoCnt_d   = tmoCnt_q;
        dinData_d  = dinData_q;
        dinVld_d   = 1'b0;
        done_d     = 1'b0;
        errTmo_d   = errTmo_q;
        srcRdy     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (frame_len_i != '0) begin
                        frameLen_d = frame_len_i;
                        smpCnt_d   = '0;
                        errTmo_d   = 1'b0;
                        state_d    = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                srcRdy = 1'b1;
                if (bus.src_vld) begin
                    dinData_d = bus.src_data;
                    dinVld_d  = 1'b1;
                    smpCnt_d  = smpCnt_q + 1'b1;
                    tmoCnt_d  = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A lost sample is abandoned: the frame ends here with the error flag raised.
                if (capture) begin
                    state_d = (smpCnt_q < frameLen_q) ? ST_ISSUE : ST_DRAIN;
                end else if (tmoCnt_q == TMO_LAST) begin
                    errTmo_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bufFull) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            frameLen_q <= '0;
            smpCnt_q   <= '0;
            tmoCnt_q   <= '0;
            dinData_q  <= '0;
            dinVld_q   <= 1'b0;
            done_q     <= 1'b0;
            errTmo_q   <= 1'b0;
            coeff_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            frameLen_q <= frameLen_d;
            smpCnt_q   <= smpCnt_d;
            tmoCnt_q   <= tmoCnt_d;
            dinData_q  <= dinData_d;
            dinVld_q   <= dinVld_d;
            done_q     <= done_d;
            errTmo_q   <= errTmo_d;
            coeff_q    <= coeff_d;
        end
    end

    always_comb begin
        coeffsFlat = '0;
        for (int k = 0; k < TAPS; k++) begin
            coeffsFlat[k*N +: N] = coeff_q[k];
        end
    end

    assign bus.src_rdy       = srcRdy;
    assign bus.fir_coeffs    = coeffsFlat;
    assign bus.fir_din_data  = dinData_q;
    assign bus.fir_din_vld   = dinVld_q;
    assign bus.fir_dout_busy = bufFull;
    assign bus.snk_vld       = bufFull;
    assign bus.snk_data      = bufData;

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign err_tmo_o = errTmo_q;

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a behavioural 8-tap FIR behind it and a result sink monitor.
module tb_fir_stream_ctrl;
    import fir_stream_ctrl_pkg::*;

    localparam int N     = 8;
    localparam int CNT_W = 16;
    localparam int TMO   = 64;
    localparam int RW    = N + 3;

    typedef struct {
        bit          we;
        logic [2:0]  addr;
        logic [7:0]  data;
        bit          st;
        logic [15:0] len;
        logic [63:0] expCoeffs;
        bit          expBusy;
        bit          expDone;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfgWe;
    logic [2:0]       cfgAddr;
    logic [N-1:0]     cfgData;
    logic             start;
    logic [CNT_W-1:0] frameLen;
    logic             busy;
    logic             done;
    logic             errTmo;

    int checkCount = 0;
    int errorCount = 0;

    fir_stream_ctrl_if #(.N(N)) bus ();

    fir_stream_ctrl #(
        .N     (N),
        .CNT_W (CNT_W),
        .TMO   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we_i    (cfgWe),
        .cfg_addr_i  (cfgAddr),
        .cfg_data_i  (cfgData),
        .start_i     (start),
        .frame_len_i (frameLen),
        .busy_o      (busy),
        .done_o      (done),
        .err_tmo_o   (errTmo),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIR: result = sum coeff[k]*x[n-k], presented two cycles after the sample and held while busy.
    logic [N-1:0]  xLine [TAPS];
    logic [RW-1:0] firAcc = '0;
    logic [RW-1:0] firData = '0;
    logic          firVld = 1'b0;
    logic          firPending = 1'b0;
    logic          busySeen = 1'b0;
    int            firWait = 0;
    bit            firSilent = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int k = 0; k < TAPS; k++) xLine[k] = '0;
            firVld = 1'b0;
            firPending = 1'b0;
            firData = '0;
            busySeen = 1'b0;
            bus.fir_dout_vld = 1'b0;
            bus.fir_dout_data = '0;
        end else begin
            if (firVld && !busySeen) firVld = 1'b0;
            if (bus.fir_din_vld === 1'b1 && !firSilent) begin
                for (int k = TAPS - 1; k > 0; k--) xLine[k] = xLine[k-1];
                xLine[0] = bus.fir_din_data;
                firAcc = '0;
                for (int k = 0; k < TAPS; k++) begin
                    firAcc = firAcc + RW'(xLine[k]) * RW'(bus.fir_coeffs[k*N +: N]);
                end
                firPending = 1'b1;
                firWait = 2;
            end else if (firPending) begin
                firWait = firWait - 1;
                if (firWait == 0) begin
                    firVld = 1'b1;
                    firData = firAcc;
                    firPending = 1'b0;
                end
            end
            busySeen = bus.fir_dout_busy;
            bus.fir_dout_vld = firVld;
            bus.fir_dout_data = firData;
        end
    end

    logic [RW-1:0] resultQ[$];
    int            doneCount = 0;

    always @(negedge clk) begin
        if (bus.snk_vld === 1'b1 && bus.snk_rdy === 1'b1) resultQ.push_back(bus.snk_data);
        if (done === 1'b1) doneCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [N-1:0]  srcVals[$];
    int            srcIdx = 0;
    int            dinLatBad = 0;
    vec_t          cfgVec[12];
    logic [RW-1:0] frameExp[$];
    logic [RW-1:0] bpExp[$];
    logic [RW-1:0] oneExp[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input bit we, input logic [2:0] a, input logic [7:0] d, input bit st,
                                   input logic [15:0] len, input logic [63:0] c, input bit b, input bit dn);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.st = st; v.len = len;
        v.expCoeffs = c; v.expBusy = b; v.expDone = dn;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        cfgWe = v.we; cfgAddr = v.addr; cfgData = v.data; start = v.st; frameLen = v.len;
        tick();
        cfgWe = 1'b0; start = 1'b0;
    endtask

    task automatic loadSource(input int count);
        srcVals.delete();
        for (int i = 0; i < count; i++) srcVals.push_back(N'(i + 1));
        srcIdx = 0;
        bus.src_vld = (count > 0);
        bus.src_data = (count > 0) ? srcVals[0] : '0;
    endtask

    // Advances one edge; a sample is taken when valid and ready are both high before the edge.
    task automatic stepSource(output bit accepted);
        accepted = (bus.src_vld === 1'b1) && (bus.src_rdy === 1'b1);
        tick();
        if (bus.fir_din_vld !== accepted) dinLatBad++;
        if (accepted) begin
            srcIdx++;
            if (srcIdx < srcVals.size()) bus.src_data = srcVals[srcIdx];
            else bus.src_vld = 1'b0;
        end
    endtask

    task automatic waitDone(input int budget, input string name);
        bit acc;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            stepSource(acc);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput({name, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic checkResults(input int base, input logic [RW-1:0] exp[$], input string name);
        checkOutput({name, "_count"}, 64'(resultQ.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < resultQ.size()) checkOutput($sformatf("%s_res%0d", name, i), resultQ[base + i], exp[i]);
            else checkOutput($sformatf("%s_res%0d_missing", name, i), 64'd0, 64'd1);
        end
    endtask

    task automatic resetAndLoad(input logic [7:0] c);
        bus.src_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < TAPS; k++) applyStimulus(mkVec(1'b1, 3'(k), c, 1'b0, 16'd0, 64'd0, 1'b0, 1'b0));
    endtask

    initial begin
        bit acc;
        int doneBase;
        int base;
        int doneAt;
        int holdBad;

        frameExp = '{11'd1, 11'd3, 11'd6, 11'd10, 11'd15, 11'd21, 11'd28, 11'd36};
        bpExp    = '{11'd1, 11'd3, 11'd6};
        oneExp   = '{11'd1};

        cfgVec[0]  = mkVec(1'b1, 3'd0, 8'h01, 1'b0, 16'd0, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        cfgVec[1]  = mkVec(1'b1, 3'd1, 8'h02, 1'b0, 16'd0, 64'h0000_0000_0000_0201, 1'b0, 1'b0);
        cfgVec[2]  = mkVec(1'b1, 3'd2, 8'h03, 1'b0, 16'd0, 64'h0000_0000_0003_0201, 1'b0, 1'b0);
        cfgVec[3]  = mkVec(1'b1, 3'd3, 8'h04, 1'b0, 16'd0, 64'h0000_0000_0403_0201, 1'b0, 1'b0);
        cfgVec[4]  = mkVec(1'b1, 3'd4, 8'h05, 1'b0, 16'd0, 64'h0000_0005_0403_0201, 1'b0, 1'b0);
        cfgVec[5]  = mkVec(1'b1, 3'd5, 8'h06, 1'b0, 16'd0, 64'h0000_0605_0403_0201, 1'b0, 1'b0);
        cfgVec[6]  = mkVec(1'b1, 3'd6, 8'h07, 1'b0, 16'd0, 64'h0007_0605_0403_0201, 1'b0, 1'b0);
        cfgVec[7]  = mkVec(1'b1, 3'd7, 8'h08, 1'b0, 16'd0, 64'h0807_0605_0403_0201, 1'b0, 1'b0);
        cfgVec[8]  = mkVec(1'b0, 3'd0, 8'h00, 1'b1, 16'd0, 64'h0807_0605_0403_0201, 1'b0, 1'b1);
        cfgVec[9]  = mkVec(1'b0, 3'd0, 8'h00, 1'b0, 16'd0, 64'h0807_0605_0403_0201, 1'b0, 1'b0);
        cfgVec[10] = mkVec(1'b1, 3'd3, 8'hAA, 1'b0, 16'd0, 64'h0807_0605_AA03_0201, 1'b0, 1'b0);
        cfgVec[11] = mkVec(1'b1, 3'd3, 8'h04, 1'b0, 16'd0, 64'h0807_0605_0403_0201, 1'b0, 1'b0);

        rst = 1'b1; cfgWe = 1'b0; cfgAddr = '0; cfgData = '0; start = 1'b0; frameLen = '0;
        bus.src_vld = 1'b0; bus.src_data = '0; bus.snk_rdy = 1'b0;
        repeat (3) tick();
        checkOutput("reset_coeffs", bus.fir_coeffs, 64'd0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err_tmo", errTmo, 0);
        checkOutput("reset_src_rdy", bus.src_rdy, 0);
        checkOutput("reset_din_vld", bus.fir_din_vld, 0);
        checkOutput("reset_snk_vld", bus.snk_vld, 0);
        checkOutput("reset_dout_busy", bus.fir_dout_busy, 0);
        rst = 1'b0;
        tick();

        $display("[TB] coefficient table and zero-length start");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(cfgVec[i]);
            checkOutput($sformatf("cfg%0d_coeffs", i), bus.fir_coeffs, cfgVec[i].expCoeffs);
            checkOutput($sformatf("cfg%0d_busy", i), busy, cfgVec[i].expBusy);
            checkOutput($sformatf("cfg%0d_done", i), done, cfgVec[i].expDone);
        end

        $display("[TB] writes and starts while busy are ignored");
        doneBase = doneCount;
        base = resultQ.size();
        loadSource(0);
        applyStimulus(mkVec(1'b0, 3'd0, 8'h00, 1'b1, 16'd1, 64'd0, 1'b0, 1'b0));
        checkOutput("run_busy", busy, 1);
        checkOutput("run_src_rdy", bus.src_rdy, 1);
        applyStimulus(mkVec(1'b1, 3'd0, 8'hFF, 1'b1, 16'd0, 64'd0, 1'b0, 1'b0));
        checkOutput("run_write_ignored", bus.fir_coeffs, 64'h0807_0605_0403_0201);
        checkOutput("run_start_no_done", done, 0);
        checkOutput("run_still_busy", busy, 1);
        bus.snk_rdy = 1'b1;
        loadSource(1);
        waitDone(100, "run");
        tick();
        checkResults(base, oneExp, "run");
        checkOutput("run_done_count", 64'(doneCount - doneBase), 1);

        $display("[TB] eight-sample frame");
        resetAndLoad(8'h01);
        checkOutput("frame_coeffs", bus.fir_coeffs, 64'h0101_0101_0101_0101);
        doneBase = doneCount;
        base = resultQ.size();
        dinLatBad = 0;
        bus.snk_rdy = 1'b1;
        loadSource(8);
        start = 1'b1; frameLen = 16'd8;
        stepSource(acc);
        start = 1'b0;
        waitDone(300, "frame");
        tick();
        checkResults(base, frameExp, "frame");
        checkOutput("frame_done_count", 64'(doneCount - doneBase), 1);
        checkOutput("frame_samples", 64'(srcIdx), 8);
        checkOutput("frame_din_latency", 64'(dinLatBad), 0);
        checkOutput("frame_busy_after", busy, 0);

        $display("[TB] sink backpressure");
        resetAndLoad(8'h01);
        doneBase = doneCount;
        base = resultQ.size();
        bus.snk_rdy = 1'b0;
        loadSource(3);
        start = 1'b1; frameLen = 16'd3;
        stepSource(acc);
        start = 1'b0;
        repeat (20) stepSource(acc);
        holdBad = 0;
        for (int i = 0; i < 5; i++) begin
            stepSource(acc);
            if (bus.fir_dout_busy !== 1'b1 || bus.src_rdy !== 1'b0 || bus.snk_vld !== 1'b1 || bus.snk_data !== 11'd1)
                holdBad++;
        end
        checkOutput("bp_hold", 64'(holdBad), 0);
        checkOutput("bp_samples_taken", 64'(srcIdx), 2);
        bus.snk_rdy = 1'b1;
        waitDone(200, "bp");
        tick();
        checkResults(base, bpExp, "bp");
        checkOutput("bp_done_count", 64'(doneCount - doneBase), 1);

        $display("[TB] watchdog timeout");
        resetAndLoad(8'h01);
        firSilent = 1'b1;
        doneBase = doneCount;
        bus.snk_rdy = 1'b1;
        loadSource(2);
        start = 1'b1; frameLen = 16'd2;
        stepSource(acc);
        start = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) stepSource(acc);
        checkOutput("tmo_first_accept", acc, 1);
        doneAt = 0;
        for (int i = 1; i <= TMO + 4 && doneAt == 0; i++) begin
            stepSource(acc);
            if (done === 1'b1) doneAt = i;
        end
        checkOutput("tmo_latency", 64'(doneAt), 64'(TMO));
        checkOutput("tmo_err_set", errTmo, 1);
        checkOutput("tmo_busy", busy, 0);
        tick();
        checkOutput("tmo_done_pulse", done, 0);
        checkOutput("tmo_done_count", 64'(doneCount - doneBase), 1);
        checkOutput("tmo_no_retry", 64'(srcIdx), 1);
        firSilent = 1'b0;
        bus.src_vld = 1'b0;
        base = resultQ.size();
        applyStimulus(mkVec(1'b0, 3'd0, 8'h00, 1'b1, 16'd1, 64'd0, 1'b0, 1'b0));
        checkOutput("tmo_err_cleared", errTmo, 0);
        checkOutput("tmo_restart_busy", busy, 1);
        loadSource(1);
        waitDone(100, "tmo_restart");
        tick();
        checkResults(base, oneExp, "tmo_restart");
        checkOutput("tmo_err_stays_clear", errTmo, 0);

        $display("[TB] reset in the middle of a frame");
        bus.snk_rdy = 1'b0;
        loadSource(5);
        start = 1'b1; frameLen = 16'd5;
        stepSource(acc);
        start = 1'b0;
        repeat (12) stepSource(acc);
        checkOutput("mid_pre_busy", busy, 1);
        checkOutput("mid_pre_snk_vld", bus.snk_vld, 1);
        doneBase = doneCount;
        rst = 1'b1;
        repeat (3) tick();
        checkOutput("mid_coeffs", bus.fir_coeffs, 64'd0);
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_src_rdy", bus.src_rdy, 0);
        checkOutput("mid_din_vld", bus.fir_din_vld, 0);
        checkOutput("mid_din_data", bus.fir_din_data, 0);
        checkOutput("mid_snk_vld", bus.snk_vld, 0);
        checkOutput("mid_snk_data", bus.snk_data, 0);
        checkOutput("mid_dout_busy", bus.fir_dout_busy, 0);
        checkOutput("mid_err_tmo", errTmo, 0);
        rst = 1'b0;
        bus.src_vld = 1'b0;
        tick();
        tick();
        checkOutput("mid_no_done", 64'(doneCount - doneBase), 0);
        checkOutput("mid_idle_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
